// File: rtl/step_sequencer.sv
// Step sequencer: loads a signed step count into the external step-count register,
// then walks it toward zero with one step pulse per unit, spaced by a programmable delay.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | load strobe, register takes latched count
// CHECK | read register flags, choose direction or finish
// PULSE | step pulse plus inc/dec strobe toward zero
// WAIT  | inter-step delay countdown (delay+1 cycles)
// DONE  | one-cycle completion pulse
module step_sequencer #(
  parameter int DATA_W  = 8,
  parameter int DELAY_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DATA_W-1:0]  count,
  input  logic [DELAY_W-1:0] delay,
  input  logic               negative,
  input  logic               positive,
  input  logic               zero,
  output logic               load,
  output logic               increment,
  output logic               decrement,
  output logic [DATA_W-1:0]  data,
  output logic               step,
  output logic               dir,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, PULSE, WAIT, DONE} state_t;

  state_t             state, state_nxt;
  logic [DELAY_W-1:0] delay_q;
  logic [DELAY_W-1:0] timer;
  logic               fwd_only;
  logic               rev_only;

  assign fwd_only = !zero && positive && !negative;
  assign rev_only = !zero && negative && !positive;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      data    <= '0;
      delay_q <= '0;
      timer   <= '0;
      dir     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start && !abort) begin
        data    <= count;
        delay_q <= delay;
      end
      if (state == CHECK && !abort) begin
        if (fwd_only)      dir <= 1'b1;
        else if (rev_only) dir <= 1'b0;
      end
      // Timer is reloaded on every pulse and counts down to the terminal value in WAIT
      if (state == PULSE)                 timer <= delay_q;
      else if (state == WAIT && timer != '0) timer <= timer - 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    increment = 1'b0;
    decrement = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  begin
        load      = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: state_nxt = (fwd_only || rev_only) ? PULSE : DONE;
      PULSE: begin
        step      = 1'b1;
        decrement = dir;
        increment = !dir;
        state_nxt = WAIT;
      end
      WAIT:  if (timer == '0) state_nxt = CHECK;
      DONE:  begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: behavioural step-count register model, expected-event
// scoreboard filled by the stimulus side and drained by an output monitor.
module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, abort;
  logic [7:0]  count;
  logic [15:0] delay;
  logic        negative, positive, zero;
  logic        load, increment, decrement, step, dir, busy, done;
  logic [7:0]  data;

  step_sequencer #(.DATA_W(8), .DELAY_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .count(count), .delay(delay),
    .negative(negative), .positive(positive), .zero(zero),
    .load(load), .increment(increment), .decrement(decrement), .data(data),
    .step(step), .dir(dir), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fl_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Register model: plain signed 8-bit value with flags; wraps like the real register
  logic signed [7:0] regm = 8'sd0;
  always @(posedge clk) begin
    if (load)           regm <= data;
    else if (increment) regm <= regm + 8'sd1;
    else if (decrement) regm <= regm - 8'sd1;
  end
  assign {negative, positive, zero} = (fl_mode == 1) ? 3'b000 :
                                      (fl_mode == 2) ? 3'b111 :
                                      {regm < 0, regm > 0, regm == 0};

  typedef struct {
    int   kind;   // 0 load, 1 step, 2 done
    int   cyc;
    logic dir;
    int   val;
  } ev_t;
  ev_t q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Expected behaviour of a move from the rules: load at E+1, steps every delay+3
  // starting E+3, done after the last one; truncated moves omit the done.
  task automatic push_move(input int c, input int d, input int fm, input int max_steps, input int e);
    ev_t ev;
    int  n;
    n = (fm != 0) ? 0 : (c < 0 ? -c : c);
    ev.kind = 0; ev.cyc = e + 1; ev.dir = 1'b0; ev.val = c;
    q.push_back(ev);
    for (int i = 0; i < n && i < max_steps; i++) begin
      ev.kind = 1; ev.cyc = e + 3 + i * (d + 3); ev.dir = (c > 0); ev.val = 0;
      q.push_back(ev);
    end
    if (max_steps >= n) begin
      ev.kind = 2; ev.cyc = e + 3 + n * (d + 3); ev.dir = 1'b0; ev.val = (fm != 0) ? c : 0;
      q.push_back(ev);
    end
  endtask

  task automatic issue(input int c, input int d, input int fm, input int max_steps, output int e);
    @(negedge clk);
    count = c[7:0];
    delay = d[15:0];
    start = 1'b1;
    e = cyc + 1;
    push_move(c, d, fm, max_steps, e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL %s timeout: %0d events outstanding", name, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    for (int i = 0; i < 5000 && cyc + 1 < t; i++) @(negedge clk);
  endtask

  task automatic expect_ev(input int k, input int sc, input logic dr, input int v);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event kind=%0d at cycle %0d (none expected)", k, sc);
      return;
    end
    e = q.pop_front();
    if (e.kind != k || e.cyc != sc || (k == 1 && e.dir != dr) || (k != 1 && e.val != v)) begin
      bad++;
      $display("FAIL event: got kind=%0d cycle=%0d dir=%0b val=%0d, expected kind=%0d cycle=%0d dir=%0b val=%0d",
               k, sc, dr, v, e.kind, e.cyc, e.dir, e.val);
    end
  endtask

  int  mon_cyc;
  bit  strobe_ok;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      mon_cyc = cyc + 1;
      if (load) expect_ev(0, mon_cyc, 1'b0, int'($signed(data)));
      if (step) expect_ev(1, mon_cyc, dir, 0);
      if (done) expect_ev(2, mon_cyc, 1'b0, int'(regm));
      if (load || increment || decrement || step) begin
        strobe_ok = ((int'(load) + int'(increment) + int'(decrement)) <= 1) &&
                    (step == (increment || decrement)) && (!step || decrement == dir);
        total++;
        if (!strobe_ok) begin
          bad++;
          $display("FAIL strobes: load=%0b inc=%0b dec=%0b step=%0b dir=%0b, required one strobe matching dir",
                   load, increment, decrement, step, dir);
        end
      end
    end
  end

  initial begin
    int e;
    int c, d;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; count = '0; delay = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_step", step, 0);
    check("reset_load", load, 0);
    check("reset_done", done, 0);
    check("reset_dir",  dir, 0);
    check("reset_data", data, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(3, 2, 0, 999, e);
    wait_idle("move_3_2");
    check("dir_after_fwd", dir, 1);

    issue(-2, 0, 0, 999, e);
    wait_idle("move_m2_0");
    check("reg_after_m2", regm, 0);
    check("dir_after_rev", dir, 0);

    issue(0, 5, 0, 999, e);
    check("zero_busy_e1", busy, 1);
    @(negedge clk); check("zero_busy_e2", busy, 1);
    @(negedge clk); check("zero_busy_e3", busy, 1);
    @(negedge clk); check("zero_busy_e4", busy, 0);
    wait_idle("move_0_5");

    issue(-128, 0, 0, 999, e);
    wait_idle("move_m128");
    check("reg_after_m128", regm, 0);

    // Abort during the WAIT that follows the second step
    issue(10, 4, 0, 2, e);
    wait_until(e + 12);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_step", step, 0);
    check("abort_reg", regm, 8);
    repeat (20) @(negedge clk);
    check("abort_leftover", q.size(), 0);
    issue(5, 1, 0, 999, e);
    wait_idle("after_abort");

    // Reset in the WAIT after the first step
    issue(4, 3, 0, 1, e);
    wait_until(e + 5);
    reset_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_dir",  dir, 0);
    check("rst_data", data, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_leftover", q.size(), 0);

    // Start pulses while busy must not disturb the move
    issue(4, 1, 0, 999, e);
    for (int t = e + 2; t < e + 3 + 4 * 4; t++) begin
      wait_until(t);
      start = (t % 3 == 0);
      count = 8'($urandom);
      delay = 16'($urandom_range(0, 9));
    end
    start = 1'b0;
    wait_idle("start_while_busy");
    check("busy_reg", regm, 0);

    // start and abort together in IDLE: nothing happens
    @(negedge clk);
    start = 1'b1; abort = 1'b1; count = 8'd7;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_abort_busy", busy, 0);

    // Flags not one-hot: none set, then all set
    fl_mode = 1;
    issue(5, 2, 1, 999, e);
    wait_idle("flags_none");
    fl_mode = 2;
    issue(-6, 1, 2, 999, e);
    wait_idle("flags_all");
    fl_mode = 0;

    for (int k = 0; k < 10; k++) begin
      c = int'($urandom_range(0, 40)) - 20;
      d = int'($urandom_range(0, 6));
      issue(c, d, 0, 999, e);
      wait_idle("random_move");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
